// File: rtl/pipelined_ripple_adder_pkg.sv
// Shared definitions for the pipelined ripple adder: mode encodings and the
// helpers that derive and sanity-check the pipeline depth.
package adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Number of ripple chunks (and register stages) for a given split.
  function automatic int nstages(input int width, input int stage_bits);
    return (stage_bits >= 1) ? (width / stage_bits) : 1;
  endfunction

  // True when the split is legal: at least one bit per stage and the width
  // divides evenly into whole chunks.
  function automatic bit cfg_ok(input int width, input int stage_bits);
    return (stage_bits >= 1) && (width >= stage_bits) && ((width % stage_bits) == 0);
  endfunction

endpackage

// File: rtl/pipelined_ripple_adder_if.sv
// Handshake bundle for the pipelined ripple adder: operand side (in_*, A, B,
// Cin, Sub) and result side (out_*, Sum, Cout, Ovf).
interface pipelined_ripple_adder_if #(
  parameter int WIDTH = 16
);
  import adder_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;

  // Issues operations and consumes results.
  modport master (
    output in_valid, A, B, Cin, Sub, out_ready,
    input  in_ready, out_valid, Sum, Cout, Ovf
  );

  // The adder itself.
  modport slave (
    input  in_valid, A, B, Cin, Sub, out_ready,
    output in_ready, out_valid, Sum, Cout, Ovf
  );

endinterface

// File: rtl/pipelined_ripple_adder_stage.sv
// One combinational ripple-carry chunk. Besides the chunk sum and carry-out it
// exposes the carry into the chunk MSB so the top chunk can form signed overflow.
module ripple_stage
  import adder_pkg::*;
#(
  parameter int STAGE_BITS = 4
) (
  input  logic [STAGE_BITS-1:0] a,
  input  logic [STAGE_BITS-1:0] b,
  input  logic                  ci,
  output logic [STAGE_BITS-1:0] s,
  output logic                  co,
  output logic                  c_msb_in
);

  // Bit-serial ripple through the chunk, tapping the carry entering the MSB.
  always_comb begin
    logic c;
    c        = ci;
    s        = '0;
    c_msb_in = 1'b0;
    for (int i = 0; i < STAGE_BITS; i++) begin
      if (i == STAGE_BITS - 1) c_msb_in = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/pipelined_ripple_adder.sv
// Pipelined add/subtract: WIDTH bits split into NSTAGES ripple chunks, one
// register stage per chunk. Unconsumed operand bits ride forward in skew
// registers, finished low sum chunks ride forward in deskew registers, and the
// last chunk lands directly in the output register so the whole result leaves
// together. A single advance signal stalls every stage at once.
module pipelined_ripple_adder
  import adder_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int STAGE_BITS = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  pipelined_ripple_adder_if.slave bus
);

  localparam int NSTAGES = nstages(WIDTH, STAGE_BITS);

  if (!cfg_ok(WIDTH, STAGE_BITS)) begin : g_cfg_check
    $error("pipelined_ripple_adder: WIDTH must be a positive multiple of STAGE_BITS");
  end

  logic             advance;
  logic             take;
  logic             cin_eff;
  logic [WIDTH-1:0] b_eff;

  logic             fin_vld;
  logic             fin_co;
  logic             fin_ovf;
  logic [WIDTH-1:0] fin_sum;

  logic             out_vld_q;
  logic             cout_q;
  logic             ovf_q;
  logic [WIDTH-1:0] sum_q;

  // The whole pipeline moves unless a result is waiting and not being taken.
  assign advance     = !out_vld_q || bus.out_ready;
  assign bus.in_ready = advance;
  assign take        = bus.in_valid && advance;

  // Subtraction is A + ~B + ~Cin, so Cin doubles as an active-high borrow-in.
  assign b_eff   = (bus.Sub == MODE_SUB) ? ~bus.B : bus.B;
  assign cin_eff = bus.Cin ^ (bus.Sub == MODE_SUB);

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stg
    logic [STAGE_BITS-1:0] a_c;
    logic [STAGE_BITS-1:0] b_c;
    logic                  ci_c;
    logic                  vld_c;
    logic [STAGE_BITS-1:0] s_c;
    logic                  co_c;
    logic                  cm_c;

    // Chunk source: live operands for the first stage, skew registers after.
    if (k == 0) begin : g_src
      assign a_c   = bus.A[STAGE_BITS-1:0];
      assign b_c   = b_eff[STAGE_BITS-1:0];
      assign ci_c  = cin_eff;
      assign vld_c = take;
    end else begin : g_src
      assign a_c   = g_stg[k-1].g_reg.a_rem_p[STAGE_BITS-1:0];
      assign b_c   = g_stg[k-1].g_reg.b_rem_p[STAGE_BITS-1:0];
      assign ci_c  = g_stg[k-1].g_reg.c_p;
      assign vld_c = g_stg[k-1].g_reg.vld_p;
    end

    ripple_stage #(
      .STAGE_BITS (STAGE_BITS)
    ) u_chunk (
      .a        (a_c),
      .b        (b_c),
      .ci       (ci_c),
      .s        (s_c),
      .co       (co_c),
      .c_msb_in (cm_c)
    );

    if (k < NSTAGES - 1) begin : g_reg
      localparam int DONE = (k + 1) * STAGE_BITS;
      localparam int LEFT = WIDTH - DONE;

      logic            vld_p;
      logic            c_p;
      logic [DONE-1:0] sum_p;
      logic [LEFT-1:0] a_rem_p;
      logic [LEFT-1:0] b_rem_p;

      logic [DONE-1:0] sum_nxt;
      logic [LEFT-1:0] a_nxt;
      logic [LEFT-1:0] b_nxt;

      // Drop the chunk just consumed; append its sum to the finished bits.
      if (k == 0) begin : g_nxt
        assign sum_nxt = s_c;
        assign a_nxt   = bus.A[WIDTH-1:STAGE_BITS];
        assign b_nxt   = b_eff[WIDTH-1:STAGE_BITS];
      end else begin : g_nxt
        assign sum_nxt = {s_c, g_stg[k-1].g_reg.sum_p};
        assign a_nxt   = g_stg[k-1].g_reg.a_rem_p[WIDTH-k*STAGE_BITS-1:STAGE_BITS];
        assign b_nxt   = g_stg[k-1].g_reg.b_rem_p[WIDTH-k*STAGE_BITS-1:STAGE_BITS];
      end

      // ---- stage boundary: chunk k result, carry, skew and deskew ----
      // Capture this chunk's carry, partial sum and remaining operands.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p   <= 1'b0;
          c_p     <= 1'b0;
          sum_p   <= '0;
          a_rem_p <= '0;
          b_rem_p <= '0;
        end else if (advance) begin
          vld_p   <= vld_c;
          c_p     <= co_c;
          sum_p   <= sum_nxt;
          a_rem_p <= a_nxt;
          b_rem_p <= b_nxt;
        end
      end
    end else begin : g_out
      // Last chunk: assemble the full word and derive the flags.
      if (k == 0) begin : g_cat
        assign fin_sum = s_c;
      end else begin : g_cat
        assign fin_sum = {s_c, g_stg[k-1].g_reg.sum_p};
      end
      assign fin_vld = vld_c;
      assign fin_co  = co_c;
      assign fin_ovf = co_c ^ cm_c;
    end
  end

  // ---- stage boundary: output register ----
  // Final stage doubles as the output register; it holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (advance) begin
      out_vld_q <= fin_vld;
      sum_q     <= fin_sum;
      cout_q    <= fin_co;
      ovf_q     <= fin_ovf;
    end
  end

  assign bus.out_valid = out_vld_q;
  assign bus.Sum       = sum_q;
  assign bus.Cout      = cout_q;
  assign bus.Ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Self-checking bench for pipelined_ripple_adder (16/4 main instance plus a
// 4/4 single-stage instance). Expected results come from integer arithmetic
// and an in-order queue whose entries age once per advancing clock edge.
module tb_pipelined_ripple_adder;

  localparam int NST = 4;

  logic clk;
  logic rst_n;

  int n_assert;
  int n_fail;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          age;
  } ent_t;

  ent_t q[$];

  pipelined_ripple_adder_if #(.WIDTH(16)) bus  ();
  pipelined_ripple_adder_if #(.WIDTH(4))  bus4 ();

  pipelined_ripple_adder #(.WIDTH(16), .STAGE_BITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  pipelined_ripple_adder #(.WIDTH(4), .STAGE_BITS(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: A+B+Cin or A-B-Cin on plain integers.
  function automatic ent_t ref_op(input logic [15:0] a, input logic [15:0] b,
                                  input bit cin, input bit sub);
    ent_t r;
    int ua, ub, sa, sb, u, s;
    ua = int'(a);
    ub = int'(b);
    sa = (a[15]) ? ua - 65536 : ua;
    sb = (b[15]) ? ub - 65536 : ub;
    if (sub) begin
      u      = ua - ub - int'(cin);
      s      = sa - sb - int'(cin);
      r.cout = (u >= 0);
    end else begin
      u      = ua + ub + int'(cin);
      s      = sa + sb + int'(cin);
      r.cout = (u > 65535);
    end
    r.sum = 16'(u);
    r.ovf = (s > 32767) || (s < -32768);
    r.age = 0;
    return r;
  endfunction

  function automatic bit model_vld();
    return (q.size() > 0) && (q[0].age >= NST);
  endfunction

  task automatic check_outputs();
    bit mv;
    mv = model_vld();
    chk("out_valid", bus.out_valid, mv);
    if (mv) begin
      chk("sum",  bus.Sum,  q[0].sum);
      chk("cout", bus.Cout, q[0].cout);
      chk("ovf",  bus.Ovf,  q[0].ovf);
    end
  endtask

  // One clock cycle: drive inputs, check in_ready, step the model at the edge,
  // then check the registered outputs.
  task automatic drive_cycle(input bit v, input logic [15:0] a, input logic [15:0] b,
                             input bit cin, input bit sub, input bit ordy);
    bit   mv, adv, xfer;
    ent_t r;
    bus.in_valid  = v;
    bus.A         = a;
    bus.B         = b;
    bus.Cin       = cin;
    bus.Sub       = sub;
    bus.out_ready = ordy;
    mv = model_vld();
    #1;
    chk("in_ready", bus.in_ready, !mv || ordy);
    adv  = !mv || ordy;
    xfer = v && adv;
    r    = ref_op(a, b, cin, sub);
    @(posedge clk);
    if (adv) begin
      if (mv) void'(q.pop_front());
      foreach (q[i]) q[i].age = q[i].age + 1;
      if (xfer) begin
        r.age = 1;
        q.push_back(r);
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic expect_out(input string tag, input logic [15:0] s, input bit c, input bit o);
    chk({tag, "_vld"},  bus.out_valid, 1'b1);
    chk({tag, "_sum"},  bus.Sum,       s);
    chk({tag, "_cout"}, bus.Cout,      c);
    chk({tag, "_ovf"},  bus.Ovf,       o);
  endtask

  initial begin
    logic [15:0] held_sum;
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.in_valid   = 1'b0; bus.A  = '0; bus.B  = '0; bus.Cin  = 1'b0; bus.Sub  = 1'b0;
    bus.out_ready  = 1'b1;
    bus4.in_valid  = 1'b0; bus4.A = '0; bus4.B = '0; bus4.Cin = 1'b0; bus4.Sub = 1'b0;
    bus4.out_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_sum",       bus.Sum,       16'h0);
    chk("rst_cout",      bus.Cout,      1'b0);
    chk("rst_ovf",       bus.Ovf,       1'b0);
    chk("rst_in_ready",  bus.in_ready,  1'b1);
    chk("rst4_out_valid", bus4.out_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed single operations with 4-cycle latency
    drive_cycle(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    chk("lat_early", bus.out_valid, 1'b0);
    idle(3);
    expect_out("add_ffff", 16'hFFFF, 1'b1, 1'b0);
    idle(1);
    drive_cycle(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    idle(3);
    expect_out("add_ovf", 16'h8000, 1'b0, 1'b1);
    idle(1);
    drive_cycle(1'b1, 16'h0003, 16'h0005, 1'b0, 1'b1, 1'b1);
    idle(3);
    expect_out("sub_borrow", 16'hFFFE, 1'b0, 1'b0);
    idle(1);
    drive_cycle(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
    idle(3);
    expect_out("sub_ovf", 16'h7FFF, 1'b1, 1'b1);
    idle(1);

    // Back-to-back issue
    drive_cycle(1'b1, 16'd1,  16'd2, 1'b0, 1'b0, 1'b1);
    drive_cycle(1'b1, 16'd10, 16'd5, 1'b1, 1'b0, 1'b1);
    drive_cycle(1'b1, 16'd9,  16'd6, 1'b1, 1'b0, 1'b1);
    drive_cycle(1'b1, 16'd0,  16'd0, 1'b0, 1'b0, 1'b1);
    expect_out("b2b_0", 16'd3, 1'b0, 1'b0);
    idle(1);
    expect_out("b2b_1", 16'd16, 1'b0, 1'b0);
    idle(1);
    expect_out("b2b_2", 16'd16, 1'b0, 1'b0);
    idle(1);
    expect_out("b2b_3", 16'd0, 1'b0, 1'b0);
    idle(1);
    chk("b2b_done", bus.out_valid, 1'b0);

    // Backpressure: fill, stall 3 cycles while offering a refused op, release
    for (int i = 0; i < NST; i++)
      drive_cycle(1'b1, 16'(100 * (i + 1)), 16'(7 + i), 1'b0, 1'b0, 1'b1);
    held_sum = bus.Sum;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 16'hDEAD, 16'hBEEF, 1'b1, 1'b0, 1'b0);
      chk("stall_in_ready", bus.in_ready, 1'b0);
      chk("stall_sum_hold", bus.Sum, held_sum);
    end
    idle(NST + 2);
    chk("drain_empty", q.size(), 0);

    // Reset with operations in flight
    for (int i = 0; i < NST; i++)
      drive_cycle(1'b1, 16'(3 * i + 1), 16'(5 * i), 1'b0, 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_sum",       bus.Sum,       16'h0);
    chk("mid_rst_cout",      bus.Cout,      1'b0);
    chk("mid_rst_ovf",       bus.Ovf,       1'b0);
    chk("mid_rst_in_ready",  bus.in_ready,  1'b1);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(NST + 2);
    drive_cycle(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
    idle(3);
    expect_out("post_rst", 16'h5555, 1'b0, 1'b0);
    idle(1);

    // Single-stage instance: latency 1
    bus4.A = 4'hF; bus4.B = 4'hF; bus4.Cin = 1'b1; bus4.Sub = 1'b0; bus4.in_valid = 1'b1;
    #1;
    chk("w4_pre_valid", bus4.out_valid, 1'b0);
    chk("w4_in_ready",  bus4.in_ready,  1'b1);
    drive_cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    bus4.in_valid = 1'b0;
    chk("w4_valid", bus4.out_valid, 1'b1);
    chk("w4_sum",   bus4.Sum,       4'hF);
    chk("w4_cout",  bus4.Cout,      1'b1);
    chk("w4_ovf",   bus4.Ovf,       1'b0);
    drive_cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("w4_bubble", bus4.out_valid, 1'b0);

    // Randomized traffic with random backpressure and corner operands
    for (int i = 0; i < 400; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 7))
        0: ra = 16'hFFFF;
        1: rb = 16'h8000;
        2: ra = 16'h7FFF;
        default: ;
      endcase
      drive_cycle(($urandom_range(0, 3) != 0), ra, rb, 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) != 0));
    end
    idle(NST + 4);
    chk("final_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
